// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code decode path.
// Helpers work on a wide vector; callers zero-extend narrower codes.
package gray_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        EMPTY,
        TRACK
    } state_e;

    // Zero-extended upper bits decode to zero, so any width <= MAX_W works.
    function automatic logic [MAX_W-1:0] gray2bin(
        input logic [MAX_W-1:0] g
    );
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(
        input logic [MAX_W-1:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter of parameterised width.
// Used as the stage-2 decoder inside the tracker.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    always_comb begin
        b = WIDTH'(gray2bin(MAX_W'(g)));
    end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray sample tracker: decode, modular delta and
// illegal multi-bit step detection with a saturating error count.
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             first,
    output logic [WIDTH-1:0] delta,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] g_s1_q, g_s1_d;
    logic             v_s1_q, v_s1_d;
    logic [WIDTH-1:0] prev_g_q, prev_g_d;
    logic [WIDTH-1:0] prev_b_q, prev_b_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             first_q, first_d;
    logic             step_err_q, step_err_d;
    logic             out_valid_q, out_valid_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] b_conv;
    logic             multi_bit;

    gray_to_binary #(
        .WIDTH(WIDTH)
    ) u_conv (
        .g(g_s1_q),
        .b(b_conv)
    );

    assign multi_bit = popcount(MAX_W'(g_s1_q ^ prev_g_q)) > 1;

    // Stage 1 capture; a clear drops the concurrent input.
    always_comb begin
        v_s1_d = in_valid && !clear;
        g_s1_d = in_valid ? G : g_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = EMPTY;
        end else if (v_s1_q) begin
            state_d = TRACK;
        end
    end

    always_comb begin
        b_d         = b_q;
        delta_d     = delta_q;
        prev_g_d    = prev_g_q;
        prev_b_d    = prev_b_q;
        err_count_d = err_count_q;
        out_valid_d = 1'b0;
        first_d     = 1'b0;
        step_err_d  = 1'b0;
        if (clear) begin
            err_count_d = '0;
        end else if (v_s1_q) begin
            out_valid_d = 1'b1;
            b_d         = b_conv;
            prev_g_d    = g_s1_q;
            prev_b_d    = b_conv;
            unique case (state_q)
                EMPTY: begin
                    first_d = 1'b1;
                    delta_d = '0;
                end
                TRACK: begin
                    delta_d    = b_conv - prev_b_q;
                    step_err_d = multi_bit;
                    if (multi_bit && err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_s1_q      <= '0;
            v_s1_q      <= 1'b0;
            prev_g_q    <= '0;
            prev_b_q    <= '0;
            b_q         <= '0;
            delta_q     <= '0;
            first_q     <= 1'b0;
            step_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            g_s1_q      <= g_s1_d;
            v_s1_q      <= v_s1_d;
            prev_g_q    <= prev_g_d;
            prev_b_q    <= prev_b_d;
            b_q         <= b_d;
            delta_q     <= delta_d;
            first_q     <= first_d;
            step_err_q  <= step_err_d;
            out_valid_q <= out_valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign B         = b_q;
    assign delta     = delta_q;
    assign first     = first_q;
    assign step_err  = step_err_q;
    assign out_valid = out_valid_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Scoreboard bench for gray_to_binary_tracker with a reference
// model built from plain Gray arithmetic and Hamming counts.
module tb_gray_to_binary_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] G = 4'h0;
    logic [3:0] B;
    logic       out_valid;
    logic       first;
    logic [3:0] delta;
    logic       step_err;
    logic [7:0] err_count;

    gray_to_binary_tracker #(
        .WIDTH(4),
        .ERR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .G(G),
        .B(B),
        .out_valid(out_valid),
        .first(first),
        .delta(delta),
        .step_err(step_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] b;
        logic       first;
        logic [3:0] delta;
        logic       se;
        logic [7:0] err;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] mpb, mpg;
    bit         have = 0;
    logic [7:0] merr = 0;
    logic [3:0] last_b = 0, last_d = 0;
    logic [7:0] last_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] decode(input logic [3:0] g);
        logic [3:0] b;
        b = 0;
        for (int k = 0; k < 4; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [3:0] enc(input logic [3:0] n);
        return n ^ (n >> 1);
    endfunction

    task automatic push(input logic [3:0] g);
        exp_t e;
        e.b = decode(g);
        e.first = !have;
        e.delta = have ? 4'(e.b - mpb) : 4'h0;
        e.se = have && ($countones(g ^ mpg) > 1);
        if (e.se && merr != 8'd255) merr = merr + 8'd1;
        e.err = merr;
        e.cyc = cyc + 2;
        mpb = e.b;
        mpg = g;
        have = 1;
        q.push_back(e);
    endtask

    task automatic send(input logic [3:0] g);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        G = g;
        push(g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            G = 4'($urandom);
        end
    endtask

    task automatic flush_model(input bit full);
        q.delete();
        have = 0;
        merr = 0;
        last_err = 0;
        if (full) begin
            last_b = 0;
            last_d = 0;
        end
    endtask

    task automatic do_clear(input logic [3:0] g);
        @(posedge clk);
        #1;
        clear = 1'b1;
        in_valid = 1'b1;
        G = g;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        flush_model(0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        exp_v = (q.size() != 0) && (q[0].cyc == cyc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        if (out_valid && q.size() != 0) begin
            e = q.pop_front();
            chk("B", {28'b0, B}, {28'b0, e.b});
            chk("first", {31'b0, first}, {31'b0, e.first});
            chk("delta", {28'b0, delta}, {28'b0, e.delta});
            chk("step_err", {31'b0, step_err}, {31'b0, e.se});
            chk("err_count", {24'b0, err_count}, {24'b0, e.err});
            last_b = e.b;
            last_d = e.delta;
            last_err = e.err;
        end else if (!out_valid) begin
            if (exp_v) void'(q.pop_front());
            chk("idle_first", {31'b0, first}, 0);
            chk("idle_step_err", {31'b0, step_err}, 0);
            chk("hold_B", {28'b0, B}, {28'b0, last_b});
            chk("hold_delta", {28'b0, delta}, {28'b0, last_d});
            chk("hold_err", {24'b0, err_count}, {24'b0, last_err});
        end
    end

    initial begin
        logic [3:0] n;
        int         r;
        int         wait_n;
        #12;
        chk("rst_B", {28'b0, B}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_err", {24'b0, err_count}, 0);
        #11 rst = 1'b0;

        for (int i = 0; i < 16; i++) send(enc(4'(i)));
        send(4'b0000);
        send(4'b0000);
        send(4'b0011);
        send(4'b0010);
        send(4'b0001);
        send(4'b0000);
        send(4'b0000);
        idle(3);

        for (int i = 0; i < 300; i++) send(i[0] ? 4'b0011 : 4'b0000);
        do_clear(4'b0110);
        idle(2);
        send(4'b0101);
        send(4'b0100);

        send(4'b0111);
        do_clear(4'b1111);
        send(4'b1100);
        idle(2);

        n = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 39));
            if (r < 8) begin
                idle(1);
            end else if (r < 13) begin
                n = 4'($urandom);
                send(enc(n));
            end else if (r == 13) begin
                do_clear(4'($urandom));
            end else begin
                n = 4'(n + 4'($urandom_range(0, 2)) - 4'd1);
                send(enc(n));
            end
        end
        idle(3);

        send(4'b0110);
        send(4'b0111);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        flush_model(1);
        #1;
        chk("arst_B", {28'b0, B}, 0);
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_delta", {28'b0, delta}, 0);
        chk("arst_err", {24'b0, err_count}, 0);
        chk("arst_first", {31'b0, first}, 0);
        chk("arst_step_err", {31'b0, step_err}, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        idle(4);
        send(4'b1010);
        send(4'b1011);
        idle(1);

        wait_n = 0;
        while (q.size() != 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d outputs still pending, expected 0",
                     q.size());
        end
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
Sequential receiver for Gray-coded counts such as pointers or position encoders, already in the local clock domain. It registers each valid Gray sample and converts it to binary in a 2-stage pipeline. It reports the modular binary delta from the previous accepted sample and flags illegal multi-bit Gray transitions. It is the decode-side partner of the team's binary-to-Gray encoder.

Parameters:
WIDTH, 4, bit width of Gray input and binary output (>=2)
ERR_W, 8, width of saturating illegal-step counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush; returns tracker to EMPTY
in_valid  input  1  G is valid this cycle
G  input  WIDTH  Gray-coded sample
B  output  WIDTH  binary value of the sample
out_valid  output  1  B/delta/step_err/first valid this cycle
first  output  1  sample is first since reset/clear (delta forced 0)
delta  output  WIDTH  (B - B_prev) mod 2^WIDTH
step_err  output  1  Hamming(G, G_prev) > 1
err_count  output  ERR_W  count of step_err pulses, saturates at 2^ERR_W-1

Behaviour:
- Reset (async, rst=1): B, delta, err_count = 0; out_valid, first, step_err = 0. Stage-1 valid = 0. prev_g = 0. State = EMPTY. Effect is immediate, including mid-stream; in-flight samples are discarded.
- Conversion: B[WIDTH-1] = G[WIDTH-1]; B[i] = B[i+1] ^ G[i] for i = WIDTH-2 down to 0.
- Stage 1, edge k: if in_valid, capture G into g_s1 and set v_s1=1; otherwise v_s1=0.
- Stage 2, edge k+1: if v_s1, register B = gray2bin(g_s1) and assert out_valid for one cycle. Update prev_g and prev_b.
- Latency: a sample presented in cycle c appears on the outputs in cycle c+2. Throughput is one sample per cycle; back-to-back samples are supported. There is no backpressure.
- State machine:
  - EMPTY: next stage-2 sample gives first=1, delta=0, step_err=0, then go to TRACK.
  - TRACK: delta = B - prev_b, truncated to WIDTH bits.
  - Hamming distance 0 or 1: step_err=0.
  - Hamming distance >1: step_err=1 for that output cycle; err_count increments unless already saturated.
  - Remains in TRACK until clear or rst.
- Outputs when out_valid=0: first, step_err = 0; B and delta hold their last values.
- Wrap-around: max-to-0 (Gray 1000 to 0000 for WIDTH=4) is a legal single-bit step with delta=1. Downward single steps give delta = 2^WIDTH-1.
- clear: synchronous and highest priority.
  - On the edge: v_s1=0, state=EMPTY, err_count=0, out_valid=0 next cycle.
  - in_valid in the same cycle as clear is dropped.
  - A sample already in stage 1 is discarded.
- in_valid=0 cycles leave prev_g and prev_b unchanged; gaps do not reset tracking.

Decomposition:
- Package gray_pkg holds:
  - function gray2bin(WIDTH);
  - function popcount of the XOR;
  - state enum {EMPTY, TRACK}.
- One natural sub-module: gray_to_binary, a purely combinational WIDTH-parameterised converter instantiated in stage 2.
- Hamming check and delta subtractor stay inline.

Test Plan (WIDTH=4, ERR_W=8):
1. Reset, then Gray codes of 0..15 on 16 consecutive cycles -> B = 0..15 starting 2 cycles after the first input; first=1 with delta=0 on the first, then delta=1 each; step_err=0; err_count=0.
2. Gray 1000 (B=15) then 0000 -> B=0, delta=1, step_err=0 (wrap legal).
3. Gray 0000 then 0011 -> B=2, delta=2, step_err=1 for one cycle, err_count=1. Follow with 0010 -> B=3, delta=1, step_err=0.
4. Gray 0001 (B=1) then 0000, then 0000 again -> delta=15, step_err=0; then delta=0, step_err=0.
5. 300 alternating illegal jumps 0000/0011 -> err_count saturates at 255, no wrap. Then assert clear -> err_count=0, next sample has first=1.
6. Assert rst asynchronously mid-edge-cycle while 2 samples are in flight -> outputs go 0 immediately. No out_valid after release until a new in_valid, which appears 2 cycles later with first=1.
